fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port between NREQ producers. Each producer offers beats on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, drives the FIFO write enable and data, and stalls on FIFO full. It sits directly in front of the team's sync FIFO, with `o_fifo_wr_en`/`o_fifo_data` wired to the FIFO's `wr_en`/`i_data` and `i_fifo_full` wired from its `o_full`.

## Interface
- `WIDTH`, default 4: data width per beat; matches the FIFO `WIDTH`.
- `NREQ`, default 4: number of requesters, ≥2.
- `BURST_LEN`, default 4: maximum consecutive beats per grant, ≥1.
- `CNT_W`, default 8: width of the accepted-beat counter.

Ports:
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_req_valid`, in, NREQ: per-requester beat valid.
- `i_req_data`, in, NREQ*WIDTH: requester k data at bits [k*WIDTH +: WIDTH].
- `o_req_ready`, out, NREQ: per-requester ready; at most one bit set.
- `i_fifo_full`, in, 1: FIFO full flag.
- `o_fifo_wr_en`, out, 1: FIFO write strobe.
- `o_fifo_data`, out, WIDTH: FIFO write data.
- `o_grant`, out, NREQ: one-hot current owner; all zero when no owner.
- `o_busy`, out, 1: high while in state GRANT.
- `o_beat_cnt`, out, CNT_W: total accepted beats, modulo 2^CNT_W.

## Operation
- State machine with two states:
  - IDLE: no owner; all `o_req_ready`, `o_grant` and `o_fifo_wr_en` are 0.
  - GRANT: `owner` register is valid.
- Transfer for requester k: `i_req_valid[k] && o_req_ready[k]`.
- `o_req_ready[k] = (state==GRANT) && (owner==k) && !i_fifo_full`.
- `o_fifo_wr_en` equals the transfer of the owner. `o_fifo_data` is the owner's data slice, or 0 in IDLE. Both are combinational.
- IDLE → GRANT when any `i_req_valid` bit is high. The winner is the first valid index searching upward from `last_owner+1`, wrapping modulo NREQ. The winner is loaded into `owner` and `last_owner`, and `burst_cnt` is cleared.
- GRANT → IDLE when either condition holds:
  - a transfer occurs and `burst_cnt == BURST_LEN-1` (burst exhausted); or
  - `i_req_valid[owner]` is 0 (owner withdrew).
- While `i_fifo_full` is high and owner valid stays high, the arbiter holds GRANT. There is no transfer and `burst_cnt` is unchanged.
- `burst_cnt` width is clog2(BURST_LEN)+1. It increments by 1 per transfer in GRANT.
- `o_beat_cnt` increments by 1 on every transfer and wraps from 2^CNT_W-1 to 0.
- A requester must hold data stable while valid is high and ready is low; the arbiter does not check this.
- Reset (asynchronous assert) sets:
  - state = IDLE, owner = 0, `last_owner` = NREQ-1 (so requester 0 wins first);
  - `burst_cnt` = 0, `o_beat_cnt` = 0.
  - All outputs read 0 immediately, including mid-burst. The beat in flight is not written.

## Timing
- Arbitration latency is one cycle: valid seen in IDLE at edge N, then ready/wr_en can assert during cycle N+1.
- Throughput is one beat per cycle within a grant.
- Each grant release costs one IDLE bubble cycle before the next owner.
- `i_fifo_full` → ready/wr_en path is combinational with zero-cycle response. A write is never issued while full.
- Fairness: each requester waits at most (NREQ-1) bursts of ≤BURST_LEN beats, plus bubbles, beyond FIFO stalls.
- Simultaneous events:
  - Burst-exhausting transfer while other requesters are valid: go to IDLE, then the next round-robin winner.
  - Owner withdraws in the same cycle another requester asserts: go to IDLE, re-arbitrate the next cycle.
- Reset deassertion: first arbitration on the first rising edge with `i_rst_n` high.

## Test plan
- Single requester: requester 2 holds valid with data 0x3,0x4,…, FIFO never full → grant 0100 the cycle after valid. 4 beats written on consecutive cycles, IDLE bubble, re-grant to 2, 4 more beats; `o_beat_cnt` = 8 after 8 beats.
- All four valid continuously after reset → grant order 0,1,2,3,0, each burst exactly 4 beats with a 1-cycle bubble between bursts; no beat lost or duplicated.
- `i_fifo_full` forced high for 3 cycles mid-burst (after beat 2) → `o_fifo_wr_en` = 0 and ready = 0 for those 3 cycles. Grant held; beats 3–4 resume after; burst still totals 4 beats.
- Owner 1 drops valid after 2 beats while requester 3 is valid → IDLE one cycle, then grant 1000; requester 1's burst had 2 beats.
- `i_rst_n` pulsed low mid-burst (after beat 1 of owner 0) → all outputs 0 during reset. Afterwards `o_beat_cnt` = 0 and the first grant goes to the lowest valid index starting from 0.
- CNT_W=4 run of 17 transfers → `o_beat_cnt` reads 0xF after 15, 0x0 after 16, 0x1 after 17.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ producers, the write arbiter and the sync FIFO
// write port. The master modport is the arbiter's view; slave is the environment.
interface fifo_wr_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       i_req_valid;
   logic [NREQ*WIDTH-1:0] i_req_data;
   logic [NREQ-1:0]       o_req_ready;
   logic                  i_fifo_full;
   logic                  o_fifo_wr_en;
   logic [WIDTH-1:0]      o_fifo_data;

   modport master (
      input  i_req_valid, i_req_data, i_fifo_full,
      output o_req_ready, o_fifo_wr_en, o_fifo_data
   );

   modport slave (
      output i_req_valid, i_req_data, i_fifo_full,
      input  o_req_ready, o_fifo_wr_en, o_fifo_data
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one producer owns the FIFO write port for a
// burst of at most BURST_LEN beats; every release costs one IDLE cycle.
// ready/wr_en react combinationally to i_fifo_full so a full FIFO is never written.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 4,
   parameter int NREQ      = 4,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   fifo_wr_arbiter_if.master  bus,
   output logic [NREQ-1:0]    o_grant,
   output logic               o_busy,
   output logic [CNT_W-1:0]   o_beat_cnt
);

   localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BC_W  = $clog2(BURST_LEN) + 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [OWN_W-1:0]  owner_q, owner_d;
   logic [OWN_W-1:0]  last_owner_q, last_owner_d;
   logic [BC_W-1:0]   burst_q, burst_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              busy_q, busy_d;

   logic [WIDTH-1:0]  owner_data_s;
   logic              owner_valid_s;
   logic              xfer_s;
   logic              any_valid_s;
   logic [OWN_W-1:0]  win_idx_s;
   logic              win_found_s;
   logic [OWN_W-1:0]  cand_s;
   logic [NREQ-1:0]   ready_s;

   // Select the current owner's valid bit and data slice.
   always_comb begin
      owner_data_s  = {WIDTH{1'b0}};
      owner_valid_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         owner_data_s  = (owner_q == OWN_W'(k)) ? bus.i_req_data[k*WIDTH +: WIDTH] : owner_data_s;
         owner_valid_s = (owner_q == OWN_W'(k)) ? bus.i_req_valid[k] : owner_valid_s;
      end
   end

   // Round-robin search: first valid index above last_owner, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {OWN_W{1'b0}};
      cand_s      = {OWN_W{1'b0}};
      for (int i = 1; i <= NREQ; i++) begin
         cand_s = OWN_W'((int'(last_owner_q) + i) % NREQ);
         if (!win_found_s && bus.i_req_valid[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Handshake outputs; a full FIFO drops ready in the same cycle.
   always_comb begin
      ready_s = {NREQ{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         ready_s[k] = (state_q == ST_GRANT) && (owner_q == OWN_W'(k)) && !bus.i_fifo_full;
      end
   end

   assign any_valid_s      = |bus.i_req_valid;
   assign xfer_s           = (state_q == ST_GRANT) && owner_valid_s && !bus.i_fifo_full;
   assign bus.o_req_ready  = ready_s;
   assign bus.o_fifo_wr_en = xfer_s;
   assign bus.o_fifo_data  = (state_q == ST_GRANT) ? owner_data_s : {WIDTH{1'b0}};

   // Next-state logic for the grant FSM and the beat counter.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_d      = burst_q;
      beat_cnt_d   = beat_cnt_q + {{(CNT_W-1){1'b0}}, xfer_s};
      case (state_q)
         ST_IDLE: begin
            if (any_valid_s && win_found_s) begin
               state_d      = ST_GRANT;
               owner_d      = win_idx_s;
               last_owner_d = win_idx_s;
               burst_d      = {BC_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!owner_valid_s) begin
               state_d = ST_IDLE;
            end else if (xfer_s) begin
               burst_d = burst_q + BC_W'(1);
               state_d = (burst_q == BC_W'(BURST_LEN - 1)) ? ST_IDLE : ST_GRANT;
            end else begin
               state_d = ST_GRANT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered grant/busy views, decoded from the next state.
   always_comb begin
      grant_d = {NREQ{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         grant_d[k] = (state_d == ST_GRANT) && (owner_d == OWN_W'(k));
      end
      busy_d = (state_d == ST_GRANT);
   end

   // FSM and counter registers; last_owner resets so requester 0 wins first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= {OWN_W{1'b0}};
         last_owner_q <= OWN_W'(NREQ - 1);
         burst_q      <= {BC_W{1'b0}};
         beat_cnt_q   <= {CNT_W{1'b0}};
         grant_q      <= {NREQ{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_q      <= burst_d;
         beat_cnt_q   <= beat_cnt_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
      end
   end

   assign o_grant    = grant_q;
   assign o_busy     = busy_q;
   assign o_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random run,
// all compared cycle by cycle against a transaction-level reference model.
module tb_fifo_wr_arbiter;
   localparam int WIDTH     = 4;
   localparam int NREQ      = 4;
   localparam int BURST_LEN = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic                  full = 1'b0;

   logic [NREQ-1:0] grant1, grant2;
   logic            busy1, busy2;
   logic [7:0]      cnt1;
   logic [3:0]      cnt2;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // model state: owner index (-1 = none), last winner, beats in burst, total beats
   int m_owner, m_last, m_beats, m_total;
   logic [25:0] exp_v, obs;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus1 ();
   fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus2 ();

   assign bus1.i_req_valid = req_valid;
   assign bus1.i_req_data  = req_data;
   assign bus1.i_fifo_full = full;
   assign bus2.i_req_valid = req_valid;
   assign bus2.i_req_data  = req_data;
   assign bus2.i_fifo_full = full;

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_LEN(BURST_LEN), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
      .o_grant(grant1), .o_busy(busy1), .o_beat_cnt(cnt1));

   fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_LEN(BURST_LEN), .CNT_W(4)) dut_w4 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus2),
      .o_grant(grant2), .o_busy(busy2), .o_beat_cnt(cnt2));

   function automatic void model_reset();
      m_owner = -1; m_last = NREQ - 1; m_beats = 0; m_total = 0;
   endfunction

   // expected outputs for the current inputs and model state
   function automatic void model_eval();
      logic [3:0] g, r, d;
      logic w;
      g = '0; r = '0; d = '0; w = 1'b0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         d = req_data[m_owner*WIDTH +: WIDTH];
         if (!full) begin
            r[m_owner] = 1'b1;
            w = req_valid[m_owner];
         end
      end
      exp_v = {g, r, w, d, (m_owner >= 0), 8'(m_total), 4'(m_total)};
   endfunction

   // advance the model across one rising edge
   function automatic void model_step();
      if (!rst_n) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int i = 1; i <= NREQ; i++) begin
            if (m_owner < 0 && req_valid[(m_last + i) % NREQ]) begin
               m_owner = (m_last + i) % NREQ;
               m_last  = m_owner;
               m_beats = 0;
            end
         end
      end else if (!req_valid[m_owner]) begin
         m_owner = -1;
      end else if (!full) begin
         m_total++;
         m_beats++;
         if (m_beats == BURST_LEN) m_owner = -1;
      end
   endfunction

   function automatic logic [25:0] obs_vec();
      return {grant1, bus1.o_req_ready, bus1.o_fifo_wr_en, bus1.o_fifo_data, busy1, cnt1, cnt2};
   endfunction

   function automatic int onehot_idx(logic [3:0] g);
      int r = -1;
      for (int k = 0; k < NREQ; k++) if (g[k]) r = k;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = '0; req_data = '0; full = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 4'b1111; req_data = 16'hABCD; full = 1'b0;
      #1;
      obs = obs_vec(); chk_cnt++;
      if (obs !== 26'h0) $display("FAIL reset_hold got=%h exp=%h", obs, 26'h0);
      else pass_cnt++;
      model_reset();
      @(negedge clk); #1;
      obs = obs_vec(); chk_cnt++;
      if (obs !== 26'h0) $display("FAIL reset_clocked got=%h exp=%h", obs, 26'h0);
      else pass_cnt++;
      rst_n = 1'b1; req_valid = '0;
      model_step();
      @(negedge clk); #1;
      model_eval(); obs = obs_vec(); chk_cnt++;
      if (obs !== exp_v) $display("FAIL reset_idle got=%h exp=%h", obs, exp_v);
      else pass_cnt++;
      model_step();
   endtask

   task automatic test_single();
      int sent = 0;
      logic [3:0] log_q[$];
      logic [3:0] g_at[10];
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = 4'b0100; full = 1'b0;
         req_data = {4'h0, 4'(3 + sent), 8'h00};
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL single cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         g_at[c] = grant1;
         if (bus1.o_req_ready[2] && req_valid[2]) begin
            log_q.push_back(bus1.o_fifo_data);
            sent++;
         end
         model_step();
      end
      chk_cnt++;
      if (g_at[0] !== 4'b0000 || g_at[1] !== 4'b0100 || g_at[5] !== 4'b0000 || g_at[6] !== 4'b0100)
         $display("FAIL single_grant got=%b/%b/%b/%b exp=0000/0100/0000/0100", g_at[0], g_at[1], g_at[5], g_at[6]);
      else pass_cnt++;
      chk_cnt++;
      if (log_q.size() != 8) $display("FAIL single_beats got=%0d exp=8", log_q.size());
      else pass_cnt++;
      for (int i = 0; i < log_q.size(); i++) begin
         chk_cnt++;
         if (log_q[i] !== 4'(3 + i)) $display("FAIL single_data idx=%0d got=%h exp=%h", i, log_q[i], 4'(3 + i));
         else pass_cnt++;
      end
      @(negedge clk); req_valid = '0; #1;
      chk_cnt++;
      if (cnt1 !== 8'd8) $display("FAIL single_cnt got=%0d exp=8", cnt1);
      else pass_cnt++;
      model_step();
   endtask

   task automatic test_all_four();
      int sent[NREQ];
      int order_q[$];
      int bl_q[$];
      int cur = 0;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] prev_g = '0;
      do_reset();
      for (int k = 0; k < NREQ; k++) sent[k] = 0;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         req_valid = 4'b1111; full = 1'b0;
         for (int k = 0; k < NREQ; k++) req_data[k*WIDTH +: WIDTH] = 4'(k*4 + sent[k]);
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL all_four cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         if (grant1 != 4'b0 && prev_g == 4'b0) order_q.push_back(onehot_idx(grant1));
         if (grant1 == 4'b0 && prev_g != 4'b0) begin bl_q.push_back(cur); cur = 0; end
         if (bus1.o_fifo_wr_en) begin cur++; sent[onehot_idx(grant1)]++; end
         prev_g = grant1;
         model_step();
      end
      chk_cnt++;
      if (order_q.size() != 5 || bl_q.size() != 5)
         $display("FAIL all_four_bursts got=%0d/%0d exp=5/5", order_q.size(), bl_q.size());
      else pass_cnt++;
      for (int i = 0; i < order_q.size() && i < 5; i++) begin
         chk_cnt++;
         if (order_q[i] != exp_order[i]) $display("FAIL all_four_order idx=%0d got=%0d exp=%0d", i, order_q[i], exp_order[i]);
         else pass_cnt++;
      end
      for (int i = 0; i < bl_q.size(); i++) begin
         chk_cnt++;
         if (bl_q[i] != BURST_LEN) $display("FAIL all_four_len idx=%0d got=%0d exp=%0d", i, bl_q[i], BURST_LEN);
         else pass_cnt++;
      end
      chk_cnt++;
      if (sent[0] != 8 || sent[1] != 4 || sent[2] != 4 || sent[3] != 4)
         $display("FAIL all_four_sent got=%0d,%0d,%0d,%0d exp=8,4,4,4", sent[0], sent[1], sent[2], sent[3]);
      else pass_cnt++;
   endtask

   task automatic test_full_stall();
      int beats = 0, stall = 0, stall_wr = 0, stall_lost = 0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         req_valid = 4'b0001;
         req_data = {12'h000, 4'(8 + beats)};
         full = (beats == 2 && stall < 3);
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL full_stall cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         if (full) begin
            stall++;
            if (bus1.o_fifo_wr_en || bus1.o_req_ready != 4'b0) stall_wr++;
            if (grant1 !== 4'b0001) stall_lost++;
         end
         if (bus1.o_fifo_wr_en) beats++;
         model_step();
      end
      chk_cnt++;
      if (stall != 3 || stall_wr != 0 || stall_lost != 0)
         $display("FAIL full_stall_hold got=%0d/%0d/%0d exp=3/0/0", stall, stall_wr, stall_lost);
      else pass_cnt++;
      chk_cnt++;
      if (beats != 4 || grant1 !== 4'b0000) $display("FAIL full_stall_len got=%0d/%b exp=4/0000", beats, grant1);
      else pass_cnt++;
   endtask

   task automatic test_withdraw();
      int sent1 = 0;
      logic [3:0] g_at[6];
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = (sent1 < 2) ? 4'b1010 : 4'b1000;
         req_data = {4'hD, 4'h0, 4'(sent1), 4'h0};
         full = 1'b0;
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL withdraw cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         g_at[c] = grant1;
         if (bus1.o_fifo_wr_en && grant1 == 4'b0010) sent1++;
         model_step();
      end
      chk_cnt++;
      if (sent1 != 2 || g_at[1] !== 4'b0010 || g_at[4] !== 4'b0000 || g_at[5] !== 4'b1000)
         $display("FAIL withdraw_seq got=%0d/%b/%b/%b exp=2/0010/0000/1000", sent1, g_at[1], g_at[4], g_at[5]);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         req_valid = 4'b1111; req_data = 16'h7654; full = 1'b0;
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL mid_reset_pre cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         if (c == 0) model_step();
      end
      #2 rst_n = 1'b0;
      #1;
      obs = obs_vec(); chk_cnt++;
      if (obs !== 26'h0) $display("FAIL mid_reset_async got=%h exp=%h", obs, 26'h0);
      else pass_cnt++;
      model_reset();
      @(negedge clk); #1;
      obs = obs_vec(); chk_cnt++;
      if (obs !== 26'h0) $display("FAIL mid_reset_hold got=%h exp=%h", obs, 26'h0);
      else pass_cnt++;
      rst_n = 1'b1; req_valid = 4'b1100;
      model_step();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL mid_reset_post cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         if (c == 0) begin
            chk_cnt++;
            if (grant1 !== 4'b0100 || cnt1 !== 8'd0) $display("FAIL mid_reset_first got=%b/%0d exp=0100/0", grant1, cnt1);
            else pass_cnt++;
         end
         model_step();
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] acc = '0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && !acc[k]) begin
               if ($urandom_range(0, 9) == 0) req_valid[k] = 1'b0;
            end else begin
               req_valid[k] = ($urandom_range(0, 2) != 0);
               req_data[k*WIDTH +: WIDTH] = 4'($urandom);
            end
         end
         full = ($urandom_range(0, 4) == 0);
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         acc = bus1.o_req_ready & req_valid;
         model_step();
      end
   endtask

   task automatic test_cnt_wrap();
      logic [3:0] exp_w[3] = '{4'hF, 4'h0, 4'h1};
      bit seen[3] = '{1'b0, 1'b0, 1'b0};
      do_reset();
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         req_valid = 4'b0001; req_data = 16'(c); full = 1'b0;
         #1;
         model_eval(); obs = obs_vec(); chk_cnt++;
         if (obs !== exp_v) $display("FAIL cnt_wrap cyc=%0d got=%h exp=%h", c, obs, exp_v);
         else pass_cnt++;
         for (int i = 0; i < 3; i++) begin
            if (m_total == 15 + i && !seen[i]) begin
               seen[i] = 1'b1;
               chk_cnt++;
               if (cnt2 !== exp_w[i]) $display("FAIL cnt_wrap_w4 after=%0d got=%h exp=%h", 15 + i, cnt2, exp_w[i]);
               else pass_cnt++;
            end
         end
         model_step();
      end
      chk_cnt++;
      if (!(seen[0] && seen[1] && seen[2])) $display("FAIL cnt_wrap_reach got=%0d exp=17", m_total);
      else pass_cnt++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_all_four();
      test_full_stall();
      test_withdraw();
      test_mid_reset();
      test_random();
      test_cnt_wrap();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
